// File: rtl/usb_rx_if.sv
// usb_rx_if: line inputs, FIFO fill level and received-packet outputs of usb_rx.
//
// Handshake: store_rx_packet_data is a one-cycle valid strobe that
// qualifies rx_packet_data. There is no ready signal. The receiver only
// raises the strobe while buffer_occupancy is below 64, and it drops the
// byte otherwise. rx_packet is a one-cycle event code that is 0 when idle.
interface usb_rx_if;
    logic       dplus_in;
    logic       dminus_in;
    logic [6:0] buffer_occupancy;
    logic [2:0] rx_packet;
    logic       rx_transfer_active;
    logic       store_rx_packet_data;
    logic [7:0] rx_packet_data;

    // Receiver side
    modport slave (
        input  dplus_in,
        input  dminus_in,
        input  buffer_occupancy,
        output rx_packet,
        output rx_transfer_active,
        output store_rx_packet_data,
        output rx_packet_data
    );

    // Line driver / FIFO side
    modport master (
        output dplus_in,
        output dminus_in,
        output buffer_occupancy,
        input  rx_packet,
        input  rx_transfer_active,
        input  store_rx_packet_data,
        input  rx_packet_data
    );
endinterface

// File: rtl/usb_rx.sv
// usb_rx: USB full-speed style packet receiver. 8 clk per bit. The inputs
// pass through 2-flop synchronizers. A D+ edge-locked bit timer samples each
// bit in the middle, the samples are NRZI-decoded, and bytes are assembled
// LSB first.
// Packets: SYNC(80), PID (3C DATA / 2D ACK / A5 NAK), payload, EOP.
// The last two payload bytes are CRC and are never stored.
// Optional macro USB_RX_PID_CHECK_EN: when defined, the receiver rejects
// any PID whose high nibble is not the complement of its low nibble.
// state_dbg exposes the FSM state.
module usb_rx (
    input  logic       clk,
    input  logic       rst,
    usb_rx_if.slave    bus,
    output logic [2:0] state_dbg
);
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_SYNC    = 3'd1;
    localparam logic [2:0] ST_PID     = 3'd2;
    localparam logic [2:0] ST_PAYLOAD = 3'd3;
    localparam logic [2:0] ST_EOP     = 3'd4;
    localparam logic [2:0] ST_ERR     = 3'd5;

    localparam logic [1:0] LINE_J   = 2'b10;
    localparam logic [1:0] LINE_K   = 2'b01;
    localparam logic [1:0] LINE_SE0 = 2'b00;

    localparam logic [2:0] CODE_NONE = 3'd0;
    localparam logic [2:0] CODE_DATA = 3'd1;
    localparam logic [2:0] CODE_ACK  = 3'd2;
    localparam logic [2:0] CODE_NAK  = 3'd3;
    localparam logic [2:0] CODE_ERR  = 3'd7;

    logic       dp_s1, dp_s2, dm_s1, dm_s2, dp_d;
    logic [2:0] bit_timer;
    logic [1:0] line;
    logic       dp_edge;
    logic       sample;
    logic [1:0] prev_line;
    logic       rx_bit;
    logic [7:0] shift;
    logic [7:0] next_byte;
    logic [2:0] bit_cnt;
    logic [7:0] hold0, hold1;
    logic [1:0] byte_cnt;
    logic [1:0] eop_cnt;
    logic [2:0] j_cnt;
    logic [2:0] pkt_code;
    logic       armed;
    logic       pid_ok;
    logic [2:0] state;

    assign line      = {dp_s2, dm_s2};
    assign dp_edge   = dp_s2 ^ dp_d;
    assign sample    = (bit_timer == 3'd3) && !dp_edge;
    assign rx_bit    = (line == prev_line);
    assign next_byte = {rx_bit, shift[7:1]};
    assign state_dbg = state;

`ifdef USB_RX_PID_CHECK_EN
    assign pid_ok = (next_byte[7:4] == ~next_byte[3:0]);
`else
    assign pid_ok = 1'b1;
`endif

    // Two-flop synchronizers plus a delayed D+ for edge detection; reset to J
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dp_s1 <= 1'b1;
            dp_s2 <= 1'b1;
            dp_d  <= 1'b1;
            dm_s1 <= 1'b0;
            dm_s2 <= 1'b0;
        end else begin
            dp_s1 <= bus.dplus_in;
            dp_s2 <= dp_s1;
            dp_d  <= dp_s2;
            dm_s1 <= bus.dminus_in;
            dm_s2 <= dm_s1;
        end
    end

    // Bit timer: re-aligns on every D+ edge, free-runs modulo 8 otherwise
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_timer <= 3'd0;
        end else if (dp_edge) begin
            bit_timer <= 3'd0;
        end else begin
            bit_timer <= bit_timer + 3'd1;
        end
    end

    // Packet FSM: decodes sampled bits, drives the store strobe and event codes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state                    <= ST_IDLE;
            prev_line                <= LINE_J;
            shift                    <= 8'h00;
            bit_cnt                  <= 3'd0;
            hold0                    <= 8'h00;
            hold1                    <= 8'h00;
            byte_cnt                 <= 2'd0;
            eop_cnt                  <= 2'd0;
            j_cnt                    <= 3'd0;
            pkt_code                 <= CODE_NONE;
            armed                    <= 1'b0;
            bus.rx_packet            <= CODE_NONE;
            bus.rx_transfer_active   <= 1'b0;
            bus.store_rx_packet_data <= 1'b0;
            bus.rx_packet_data       <= 8'h00;
        end else begin
            bus.rx_packet            <= CODE_NONE;
            bus.store_rx_packet_data <= 1'b0;
            if (sample) begin
                prev_line <= line;
            end

            case (state)
                ST_IDLE: begin
                    // Start only after a J has been seen, so reset never begins mid-packet
                    if (dp_edge && (line == LINE_K) && armed) begin
                        state                  <= ST_SYNC;
                        bus.rx_transfer_active <= 1'b1;
                        bit_cnt                <= 3'd0;
                        shift                  <= 8'h00;
                        byte_cnt               <= 2'd0;
                        eop_cnt                <= 2'd0;
                        armed                  <= 1'b0;
                    end else if (sample) begin
                        armed <= (line == LINE_J);
                    end
                end

                ST_SYNC, ST_PID, ST_PAYLOAD: begin
                    if (sample) begin
                        if (line == LINE_SE0) begin
                            // SE0 is legal only on a payload byte boundary
                            if ((state == ST_PAYLOAD) && (bit_cnt == 3'd0)) begin
                                state    <= ST_EOP;
                                eop_cnt  <= 2'd1;
                                pkt_code <= (byte_cnt == 2'd2) ? CODE_DATA : CODE_ERR;
                            end else begin
                                state         <= ST_ERR;
                                bus.rx_packet <= CODE_ERR;
                                j_cnt         <= 3'd0;
                            end
                        end else if ((line != LINE_J) && (line != LINE_K)) begin
                            state         <= ST_ERR;
                            bus.rx_packet <= CODE_ERR;
                            j_cnt         <= 3'd0;
                        end else begin
                            shift   <= next_byte;
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                if (state == ST_SYNC) begin
                                    if (next_byte == 8'h80) begin
                                        state <= ST_PID;
                                    end else begin
                                        state         <= ST_ERR;
                                        bus.rx_packet <= CODE_ERR;
                                        j_cnt         <= 3'd0;
                                    end
                                end else if (state == ST_PID) begin
                                    if (!pid_ok) begin
                                        state         <= ST_ERR;
                                        bus.rx_packet <= CODE_ERR;
                                        j_cnt         <= 3'd0;
                                    end else if (next_byte == 8'h3C) begin
                                        state    <= ST_PAYLOAD;
                                        byte_cnt <= 2'd0;
                                    end else if (next_byte == 8'h2D) begin
                                        state    <= ST_EOP;
                                        eop_cnt  <= 2'd0;
                                        pkt_code <= CODE_ACK;
                                    end else if (next_byte == 8'hA5) begin
                                        state    <= ST_EOP;
                                        eop_cnt  <= 2'd0;
                                        pkt_code <= CODE_NAK;
                                    end else begin
                                        state         <= ST_ERR;
                                        bus.rx_packet <= CODE_ERR;
                                        j_cnt         <= 3'd0;
                                    end
                                end else begin
                                    // Release the byte two behind; the final two stay as CRC
                                    if (byte_cnt == 2'd2) begin
                                        if (bus.buffer_occupancy == 7'd64) begin
                                            state         <= ST_ERR;
                                            bus.rx_packet <= CODE_ERR;
                                            j_cnt         <= 3'd0;
                                        end else begin
                                            bus.store_rx_packet_data <= 1'b1;
                                            bus.rx_packet_data       <= hold1;
                                        end
                                    end else begin
                                        byte_cnt <= byte_cnt + 2'd1;
                                    end
                                    hold1 <= hold0;
                                    hold0 <= next_byte;
                                end
                            end
                        end
                    end
                end

                ST_EOP: begin
                    // Expect SE0, SE0, then J
                    if (sample) begin
                        if ((eop_cnt != 2'd2) && (line == LINE_SE0)) begin
                            eop_cnt <= eop_cnt + 2'd1;
                        end else if ((eop_cnt == 2'd2) && (line == LINE_J)) begin
                            state                  <= ST_IDLE;
                            bus.rx_packet          <= pkt_code;
                            bus.rx_transfer_active <= 1'b0;
                            armed                  <= 1'b1;
                        end else begin
                            state         <= ST_ERR;
                            bus.rx_packet <= CODE_ERR;
                            j_cnt         <= 3'd0;
                        end
                    end
                end

                ST_ERR: begin
                    // Stay busy until the line has idled for 8 consecutive J bits
                    if (sample) begin
                        if (line == LINE_J) begin
                            if (j_cnt == 3'd7) begin
                                state                  <= ST_IDLE;
                                bus.rx_transfer_active <= 1'b0;
                                armed                  <= 1'b1;
                                j_cnt                  <= 3'd0;
                            end else begin
                                j_cnt <= j_cnt + 3'd1;
                            end
                        end else begin
                            j_cnt <= 3'd0;
                        end
                    end
                end

                default: begin
                    state                  <= ST_IDLE;
                    bus.rx_transfer_active <= 1'b0;
                end
            endcase
        end
    end
endmodule
